// File: rtl/switch_input_handshake.sv
// switch_input_handshake: synchronises the board switches and the "enter" button,
// debounces the button and hands the CPU a stable switch word (in_port) together
// with a clean level (ready_in) that rises once per accepted press and falls once
// per accepted release.
//
// Optional build macro SWITCH_INPUT_PRESS_COUNT_EN adds an 8-bit press_count
// output that counts accepted presses (wraps 255 -> 0) for LED bring-up.

module switch_input_handshake #(
   parameter int unsigned BUS_WIDTH       = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 1000,
   parameter int unsigned SYNC_STAGES     = 2
) (
   input  logic                 clk,
   input  logic                 n_reset,
   input  logic [BUS_WIDTH-1:0] sw_raw,
   input  logic                 btn_raw,
   output logic [BUS_WIDTH-1:0] in_port,
   output logic                 ready_in
`ifdef SWITCH_INPUT_PRESS_COUNT_EN
   ,
   output logic [7:0]           press_count
`endif
);

   // Counter wide enough to hold DEBOUNCE_CYCLES itself; it never needs to go past
   // DEBOUNCE_CYCLES-1, the ceiling only guards against wrapping.
   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      StIdle,
      StPressDb,
      StPressed,
      StReleaseDb
   } state_e;

   // ------------------------------------------------------------------
   // Input synchronisers
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] btn_sync_q;
   logic [BUS_WIDTH-1:0]   sw_sync_q [SYNC_STAGES];
   logic                   btn_s;
   logic [BUS_WIDTH-1:0]   sw_s;

   // Shift each raw input through SYNC_STAGES flops; only the last stage is used.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         btn_sync_q <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sw_sync_q[i] <= '0;
         end
      end else begin
         btn_sync_q   <= {btn_sync_q[SYNC_STAGES-2:0], btn_raw};
         sw_sync_q[0] <= sw_raw;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sw_sync_q[i] <= sw_sync_q[i-1];
         end
      end
   end

   assign btn_s = btn_sync_q[SYNC_STAGES-1];
   assign sw_s  = sw_sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Debounce FSM
   // ------------------------------------------------------------------
   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 ready_q, ready_d;
   logic [BUS_WIDTH-1:0] data_q, data_d;
   logic                 accept_press;
`ifdef SWITCH_INPUT_PRESS_COUNT_EN
   logic [7:0]           count_q, count_d;
`endif

   // State register plus the registered outputs, all cleared asynchronously.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         data_q  <= '0;
`ifdef SWITCH_INPUT_PRESS_COUNT_EN
         count_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         data_q  <= data_d;
`ifdef SWITCH_INPUT_PRESS_COUNT_EN
         count_q <= count_d;
`endif
      end
   end

   // Next-state logic: a level change is accepted only after the debounce window,
   // any contrary sample sends the FSM back to its stable state.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      accept_press = 1'b0;
      case (state_q)
         StIdle: begin
            if (btn_s) begin
               state_d = StPressDb;
               cnt_d   = '0;
            end
         end
         StPressDb: begin
            if (!btn_s) begin
               state_d = StIdle;
            end else if (cnt_q == CNT_LAST) begin
               state_d      = StPressed;
               accept_press = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StPressed: begin
            if (!btn_s) begin
               state_d = StReleaseDb;
               cnt_d   = '0;
            end
         end
         StReleaseDb: begin
            if (btn_s) begin
               state_d = StPressed;
            end else if (cnt_q == CNT_LAST) begin
               state_d = StIdle;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
   end

   // Output next values: ready follows the pressed side of the FSM, the switch word
   // is captured only at the moment a press is accepted so in_port never glitches.
   always_comb begin
      ready_d = (state_d == StPressed) || (state_d == StReleaseDb);
      data_d  = accept_press ? sw_s : data_q;
`ifdef SWITCH_INPUT_PRESS_COUNT_EN
      count_d = accept_press ? count_q + 8'd1 : count_q;
`endif
   end

   assign ready_in = ready_q;
   assign in_port  = data_q;
`ifdef SWITCH_INPUT_PRESS_COUNT_EN
   assign press_count = count_q;
`endif

   // ------------------------------------------------------------------
   // Internal consistency checks
   // ------------------------------------------------------------------
   ready_matches_state : assert property (@(posedge clk) disable iff (!n_reset)
      ready_q == ((state_q == StPressed) || (state_q == StReleaseDb)));

   cnt_in_window : assert property (@(posedge clk) disable iff (!n_reset)
      cnt_q <= CNT_LAST);

endmodule

// File: tb/tb_switch_input_handshake.sv
// Bench for switch_input_handshake (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// A stimulus process drives inputs on the falling edge and pushes the expected
// post-edge outputs from a reference model; a monitor pops and compares after
// every rising edge.

module tb_switch_input_handshake;

   localparam int unsigned BW = 8;
   localparam int unsigned DB = 4;
   localparam int unsigned SS = 2;

   logic          clk = 1'b0;
   logic          n_reset;
   logic [BW-1:0] sw_raw;
   logic          btn_raw;
   logic [BW-1:0] in_port;
   logic          ready_in;
`ifdef SWITCH_INPUT_PRESS_COUNT_EN
   logic [7:0]    press_count;
`endif

   always #5 clk = ~clk;

   switch_input_handshake #(
      .BUS_WIDTH      (BW),
      .DEBOUNCE_CYCLES(DB),
      .SYNC_STAGES    (SS)
   ) dut (
      .clk     (clk),
      .n_reset (n_reset),
      .sw_raw  (sw_raw),
      .btn_raw (btn_raw),
      .in_port (in_port),
      .ready_in(ready_in)
`ifdef SWITCH_INPUT_PRESS_COUNT_EN
      ,
      .press_count(press_count)
`endif
   );

   typedef struct packed {
      logic          ready;
      logic [BW-1:0] data;
      logic [7:0]    count;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: raw samples reach the debouncer SS edges late; a new button
   // level is believed once it is seen on DB+1 successive edges (first sighting
   // plus DB stable cycles). The switch word seen on the accepting edge is latched.
   bit            m_hist[$];
   logic [BW-1:0] m_sw_hist[$];
   bit            m_pressed;
   int            m_run;
   logic [BW-1:0] m_data;
   logic [7:0]    m_count;

   function automatic void model_reset();
      m_hist.delete();
      m_sw_hist.delete();
      for (int i = 0; i < SS; i++) begin
         m_hist.push_back(1'b0);
         m_sw_hist.push_back('0);
      end
      m_pressed = 1'b0;
      m_run     = 0;
      m_data    = '0;
      m_count   = '0;
   endfunction

   function automatic void model_edge(bit btn, logic [BW-1:0] sw);
      bit            seen_btn;
      logic [BW-1:0] seen_sw;
      seen_btn = m_hist.pop_front();
      seen_sw  = m_sw_hist.pop_front();
      m_hist.push_back(btn);
      m_sw_hist.push_back(sw);
      if (seen_btn != m_pressed) m_run++;
      else m_run = 0;
      if (m_run == int'(DB) + 1) begin
         m_pressed = seen_btn;
         m_run     = 0;
         if (seen_btn) begin
            m_data  = seen_sw;
            m_count = m_count + 8'd1;
         end
      end
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus: inputs change on the falling edge, expectation for the
   // following rising edge goes into the scoreboard.
   task automatic cycle(bit rst_n, bit btn, logic [BW-1:0] sw);
      @(negedge clk);
      n_reset = rst_n;
      btn_raw = btn;
      sw_raw  = sw;
      if (rst_n) model_edge(btn, sw);
      else model_reset();
      sb_q.push_back('{ready: m_pressed, data: m_data, count: m_count});
   endtask

   // Monitor: compare every registered output after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_ready_in", 32'(ready_in), 32'(e.ready));
            check("sb_in_port", 32'(in_port), 32'(e.data));
`ifdef SWITCH_INPUT_PRESS_COUNT_EN
            check("sb_press_count", 32'(press_count), 32'(e.count));
`endif
         end
      end
   end

   // Hold the given inputs for n cycles and report edges until ready_in == level.
   task automatic measure(bit btn, logic [BW-1:0] sw, bit level, int n, output int lat);
      lat = -1;
      cycle(1'b1, btn, sw);
      for (int j = 0; j < n; j++) begin
         @(posedge clk);
         #2;
         if (ready_in == level && lat < 0) lat = j;
         cycle(1'b1, btn, sw);
      end
   endtask

   int lat;
   bit seen;

   initial begin
      n_reset = 1'b0;
      btn_raw = 1'b0;
      sw_raw  = '0;
      model_reset();
      #1;
      check("reset_ready_in", 32'(ready_in), 32'd0);
      check("reset_in_port", 32'(in_port), 32'd0);
      repeat (3) cycle(1'b0, 1'b0, 8'h00);

      // 1: clean press, latency SS+DB edges after E0
      repeat (2) cycle(1'b1, 1'b0, 8'h00);
      measure(1'b1, 8'hA5, 1'b1, 10, lat);
      check("press_latency", 32'(lat), 32'd6);
      check("press_in_port", 32'(in_port), 32'hA5);
      measure(1'b0, 8'hA5, 1'b0, 10, lat);
      check("release_latency_1", 32'(lat), 32'd6);

      // 2: bouncing button never accepted
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, (i % 2) == 0, 8'h11);
         #1;
         if (ready_in) seen = 1'b1;
      end
      repeat (10) begin
         cycle(1'b1, 1'b0, 8'h11);
         #1;
         if (ready_in) seen = 1'b1;
      end
      check("bounce_ready_in", 32'(seen), 32'd0);
      check("bounce_in_port", 32'(in_port), 32'hA5);

      // 3: switches change while held, in_port keeps the word from the press
      measure(1'b1, 8'h3C, 1'b1, 10, lat);
      check("press_latency_3c", 32'(lat), 32'd6);
      repeat (10) cycle(1'b1, 1'b1, 8'hFF);
      check("held_in_port", 32'(in_port), 32'h3C);
      measure(1'b0, 8'hFF, 1'b0, 10, lat);
      check("release_latency_3c", 32'(lat), 32'd6);
      check("idle_in_port", 32'(in_port), 32'h3C);

      // 4: short low pulse while pressed is a release bounce
      measure(1'b1, 8'h5A, 1'b1, 10, lat);
      check("press_latency_5a", 32'(lat), 32'd6);
      seen = 1'b0;
      repeat (2) begin
         cycle(1'b1, 1'b0, 8'h5A);
         #1;
         if (!ready_in) seen = 1'b1;
      end
      repeat (10) begin
         cycle(1'b1, 1'b1, 8'h5A);
         #1;
         if (!ready_in) seen = 1'b1;
      end
      check("release_bounce_drop", 32'(seen), 32'd0);
      repeat (10) cycle(1'b1, 1'b0, 8'h5A);

      // 5: reset in the middle of a press debounce, button still held
      repeat (4) cycle(1'b1, 1'b1, 8'h77);
      cycle(1'b0, 1'b1, 8'h77);
      #1;
      check("async_reset_ready_in", 32'(ready_in), 32'd0);
      check("async_reset_in_port", 32'(in_port), 32'd0);
      cycle(1'b0, 1'b1, 8'h77);
      measure(1'b1, 8'h77, 1'b1, 10, lat);
      check("post_reset_latency", 32'(lat), 32'd6);
      check("post_reset_in_port", 32'(in_port), 32'h77);
      repeat (10) cycle(1'b1, 1'b0, 8'h77);

      // Random segments with occasional resets
      for (int s = 0; s < 300; s++) begin
         bit            b;
         int            len;
         logic [BW-1:0] w;
         b   = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 12);
         w   = BW'($urandom);
         if ($urandom_range(0, 39) == 0) begin
            repeat ($urandom_range(1, 2)) cycle(1'b0, b, w);
         end
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 3) == 0) w = BW'($urandom);
            cycle(1'b1, b, w);
         end
      end

`ifdef SWITCH_INPUT_PRESS_COUNT_EN
      // 6: 257 clean presses wrap the counter to 1
      repeat (2) cycle(1'b0, 1'b0, 8'h00);
      for (int p = 0; p < 257; p++) begin
         repeat (8) cycle(1'b1, 1'b1, 8'(p));
         repeat (8) cycle(1'b1, 1'b0, 8'(p));
      end
      check("press_count_wrap", 32'(press_count), 32'd1);
`endif

      repeat (3) cycle(1'b1, 1'b0, 8'h00);
      @(posedge clk);
      #3;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/switch_input_handshake.md
Name: switch_input_handshake

Overview:
- Front-end input stage that sits directly upstream of the CPU and drives its in_port and ready_in inputs.
- Synchronises the raw board switches and the raw "enter" push-button, then debounces the button.
- On each debounced press it latches a stable switch word and raises ready_in.
- Guarantees the CPU's wait-for-ready and wait-for-rising-edge instructions see exactly one clean edge per physical press, with in_port stable throughout.

Parameters:
BUS_WIDTH, 8, width of the switch bus and in_port
DEBOUNCE_CYCLES, 1000, consecutive stable synchronised cycles required to accept a press or a release; legal range >= 1
SYNC_STAGES, 2, flip-flop stages in each input synchroniser; legal range >= 2

Ports:
clk  input  1  system clock
n_reset  input  1  asynchronous active-low reset
sw_raw  input  BUS_WIDTH  raw asynchronous switch inputs
btn_raw  input  1  raw asynchronous push-button, active-high, bouncy
in_port  output  BUS_WIDTH  latched switch word to the CPU
ready_in  output  1  debounced button level to the CPU

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low on n_reset; every flop clears on n_reset low.
- Reset values: in_port = 0, ready_in = 0, state = IDLE, debounce counter = 0, all synchroniser stages = 0.
- Synchronisers: sw_raw and btn_raw each pass through SYNC_STAGES flops. btn_s and sw_s denote the final stages. No logic may read a raw input directly.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter saturates and never wraps.
- State machine, registered, evaluated every rising clk edge:
  - IDLE: if btn_s = 1, go to PRESS_DB with cnt = 0; otherwise stay.
  - PRESS_DB:
    - if btn_s = 0, return to IDLE (bounce rejected; in_port unchanged).
    - else if cnt = DEBOUNCE_CYCLES-1, go to PRESSED; in_port <= sw_s; ready_in <= 1.
    - else cnt <= cnt+1.
  - PRESSED: if btn_s = 0, go to RELEASE_DB with cnt = 0; otherwise stay.
  - RELEASE_DB:
    - if btn_s = 1, return to PRESSED (release bounce rejected; ready_in stays 1).
    - else if cnt = DEBOUNCE_CYCLES-1, go to IDLE; ready_in <= 0.
    - else cnt <= cnt+1.
- ready_in is 1 exactly in PRESSED and RELEASE_DB. It is a registered output with no combinational path from any input.
- in_port changes only on the PRESS_DB->PRESSED edge. It holds its value across release and idle until the next accepted press. The CPU samples switches two cycles late, so in_port must never glitch.
- Latency: with btn_raw held high from sampling edge E0, ready_in is 1 after edge E0 + SYNC_STAGES + DEBOUNCE_CYCLES. For SYNC_STAGES = 2 and DEBOUNCE_CYCLES = 4, that is after edge E6.
- Release latency: with btn_raw held low from edge R0, ready_in is 0 after edge R0 + SYNC_STAGES + DEBOUNCE_CYCLES.
- sw_raw changing while the button is held has no effect on in_port.
- Reset mid-debounce or mid-press: immediate return to reset values. No press is reported until btn_s is seen high again for the full debounce window. A button already held at reset release counts as a new press once debounced.
- DEBOUNCE_CYCLES = 1: one stable synchronised cycle accepts the event. Legal.

Optional Feature:
- Macro: SWITCH_INPUT_PRESS_COUNT_EN.
- Defined: an extra output port press_count (8 bits, reset 0) increments by 1 on every PRESS_DB->PRESSED transition, wrapping 255->0. It is for board-level bring-up on LEDs.
- Undefined: the port and its counter do not exist. All other behaviour is identical.

Test Plan:
1. Reset, then hold btn_raw=1 with sw_raw=8'hA5 (DEBOUNCE_CYCLES=4, SYNC_STAGES=2) -> ready_in=1 and in_port=8'hA5 after edge E0+6; both are 0 before that edge.
2. Bounce the button: btn_raw toggles 1,0,1,0 every cycle for 10 cycles, then settles at 0 -> ready_in stays 0 and in_port unchanged throughout.
3. Press accepted with sw=8'h3C, then sw_raw changes to 8'hFF while held, then release -> in_port stays 8'h3C. ready_in falls 6 edges after a stable release. in_port is still 8'h3C in IDLE.
4. Release bounce: in PRESSED, btn_raw pulses low for 2 cycles then returns high -> ready_in never drops and the state returns to PRESSED.
5. Assert n_reset low during PRESS_DB with btn_raw still high, then release reset -> in_port=0 and ready_in=0 immediately; a fresh full debounce window is needed before ready_in=1.
6. With SWITCH_INPUT_PRESS_COUNT_EN defined, perform 257 clean presses -> press_count=1. Without the macro, the bench confirms the port is absent and results 1–5 match.
